load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
MEM-stage initiator for the word-organised data memory. Converts pipeline load/store requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular MemRead/MemWrite accesses. Performs byte-lane extraction and sign/zero extension on loads. Implements SB/SH as a two-cycle read-modify-write, stalling the pipeline for one cycle.

Parameters:
MEM_WORDS, 32, data memory depth in 32-bit words; a word index >= MEM_WORDS is an access fault.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
req_valid  input  1  MEM-stage access request; held stable by the pipeline while stall=1
req_write  input  1  1=store, 0=load
funct3  input  3  0=B, 1=H, 2=W, 4=BU, 5=HU; 3/6/7 invalid
addr  input  32  byte address (ALU result)
store_data  input  32  rs2 value; byte/half taken from the low bits
stall  output  1  combinational; high during the RMW read cycle
load_data  output  32  registered, extended load result
load_valid  output  1  registered one-cycle pulse with load_data
fault  output  1  registered one-cycle pulse: misaligned, invalid funct3 or out-of-range
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable, sampled by memory on posedge clk
ALUresult  output  32  word-aligned address {addr[31:2],2'b00}
MemWriteData  output  32  store word
MemReadData  input  32  combinational read data from memory

Behaviour:
- Reset (rst=0, async): state=IDLE; load_data=0, load_valid=0, fault=0, rmw buffer=0. Combinational outputs MemRead=0, MemWrite=0, stall=0, MemWriteData=0.
- Byte lanes are little-endian: byte k = bits [8k+7:8k] of the word.
- Fault check (combinational): H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 3/6/7; addr[31:2] >= MEM_WORDS. On fault: no MemRead/MemWrite; fault=1 next cycle; load_valid=0.
- MemRead and MemWrite are never high in the same cycle. Both are 0 when req_valid=0.
- ALUresult = {addr[31:2],2'b00} whenever req_valid=1, else 0.
- FSM states: IDLE, RMW_WR.
- IDLE, load: MemRead=1. At posedge, load_data <= the selected lane, sign-extended for B/H and zero-extended for BU/HU. load_valid <= 1. Latency is 1 cycle; no stall.
- IDLE, SW: MemWrite=1 and MemWriteData=store_data in the same cycle; no stall.
- IDLE, SB/SH: MemRead=1, stall=1. At posedge, buffer <= MemReadData with the addressed lane(s) replaced by store_data[7:0] or store_data[15:0]; next state is RMW_WR.
- RMW_WR: MemWrite=1, MemWriteData=buffer, stall=0, MemRead=0. Next state is IDLE unconditionally. The pipeline advances at the end of this cycle.
- load_valid and fault are 0 in every cycle not covered above.
- Reset during RMW_WR: the state returns to IDLE immediately and no write is issued.
- req_valid dropping in RMW_WR is a protocol violation; the write still completes from the buffer.
- Back-to-back requests: a request accepted in RMW_WR's following cycle is handled normally. There is no forwarding between consecutive accesses beyond memory ordering.

Test Plan:
1. SW addr=0x8 data=0x80FF1234 -> same cycle MemWrite=1, ALUresult=0x8, MemWriteData=0x80FF1234; stall=0.
2. LB addr=0xB, LBU addr=0xB, LH addr=0xA, LHU addr=0xA, each on word 0x80FF1234 -> load_data respectively 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF; load_valid pulses one cycle after each request.
3. SB addr=0x9 data=0xAB on word 0x80FF1234 -> cycle 0: MemRead=1, stall=1. Cycle 1: MemWrite=1, MemWriteData=0x80FFAB34. A following LW addr=0x8 returns 0x80FFAB34.
4. SH addr=0x2 data=0xBEEF on word0=0x00000015 -> MemWriteData=0xBEEF0015 in RMW_WR; the subsequent LW addr=0x0 returns it.
5. LW addr=0x6, SH addr=0x3, funct3=3, and LW addr=0x80 (MEM_WORDS=32) -> no MemRead/MemWrite; fault pulses next cycle; load_valid=0.
6. Assert rst=0 in the SB RMW_WR cycle -> MemWrite=0 immediately, state=IDLE, memory word unchanged; all registered outputs are 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Pipeline request and data-memory bus seen by the load/store unit.
interface load_store_unit_if;
    localparam int unsigned DATA_W = 32;

    logic                req_valid;
    logic                req_write;
    logic [2:0]          funct3;
    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   store_data;
    logic                stall;
    logic [DATA_W-1:0]   load_data;
    logic                load_valid;
    logic                fault;
    logic                MemRead;
    logic                MemWrite;
    logic [DATA_W-1:0]   ALUresult;
    logic [DATA_W-1:0]   MemWriteData;
    logic [DATA_W-1:0]   MemReadData;

    // Load/store unit side
    modport slave (
        input  req_valid, req_write, funct3, addr, store_data, MemReadData,
        output stall, load_data, load_valid, fault,
               MemRead, MemWrite, ALUresult, MemWriteData
    );

    // Pipeline + memory side
    modport master (
        output req_valid, req_write, funct3, addr, store_data, MemReadData,
        input  stall, load_data, load_valid, fault,
               MemRead, MemWrite, ALUresult, MemWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-granular memory access, load lane
// extraction/extension, and two-cycle read-modify-write for SB/SH.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WIDX_W = 30;

    typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   load_data_q;
    logic                load_valid_q;
    logic                fault_q;
    logic [DATA_W-1:0]   buffer_q;
    logic [WIDX_W-1:0]   widx_q;

    logic                bad_funct3, misaligned, out_of_range, is_fault;
    logic                accept, is_rmw;
    logic [1:0]          size;
    logic [4:0]          byte_shift, half_shift;
    logic [DATA_W-1:0]   rd_byte_sh, rd_half_sh;
    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   lane_mask, lane_data, merged;

    // Request decode, fault detection and load/merge datapath
    always_comb begin
        size       = bus.funct3[1:0];
        bad_funct3 = 1'b0;
        case (bus.funct3)
            3'd3, 3'd6, 3'd7: bad_funct3 = 1'b1;
            default:          bad_funct3 = 1'b0;
        endcase
        misaligned   = ((size == 2'd1) && bus.addr[0]) ||
                       ((size == 2'd2) && (bus.addr[1:0] != 2'b00));
        out_of_range = 32'(bus.addr[31:2]) >= 32'(MEM_WORDS);
        is_fault     = bad_funct3 || misaligned || out_of_range;
        accept       = bus.req_valid && !is_fault;
        is_rmw       = accept && bus.req_write && (size != 2'd2);

        byte_shift = 5'({bus.addr[1:0], 3'b000});
        half_shift = 5'({bus.addr[1], 4'b0000});
        rd_byte_sh = bus.MemReadData >> byte_shift;
        rd_half_sh = bus.MemReadData >> half_shift;
        sel_byte   = rd_byte_sh[7:0];
        sel_half   = rd_half_sh[15:0];

        case (bus.funct3)
            3'd0:    load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'd1:    load_ext = {{16{sel_half[15]}}, sel_half};
            3'd4:    load_ext = {24'h0, sel_byte};
            3'd5:    load_ext = {16'h0, sel_half};
            default: load_ext = bus.MemReadData;
        endcase

        if (size == 2'd0) begin
            lane_mask = 32'h0000_00FF << byte_shift;
            lane_data = {24'h0, bus.store_data[7:0]} << byte_shift;
        end else begin
            lane_mask = 32'h0000_FFFF << half_shift;
            lane_data = {16'h0, bus.store_data[15:0]} << half_shift;
        end
        merged = (bus.MemReadData & ~lane_mask) | (lane_data & lane_mask);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: SB/SH spend one extra cycle writing the merged word
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_rmw) state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs; forced quiet while reset is asserted
    always_comb begin
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.stall        = 1'b0;
        bus.MemWriteData = '0;
        bus.ALUresult    = bus.req_valid ? {bus.addr[31:2], 2'b00} : '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!bus.req_write) begin
                            bus.MemRead = 1'b1;
                        end else if (is_rmw) begin
                            bus.MemRead = 1'b1;
                            bus.stall   = 1'b1;
                        end else begin
                            bus.MemWrite     = 1'b1;
                            bus.MemWriteData = bus.store_data;
                        end
                    end
                end
                RMW_WR: begin
                    // Address comes from the latched request so the write
                    // lands correctly even if req_valid misbehaves.
                    bus.MemWrite     = 1'b1;
                    bus.MemWriteData = buffer_q;
                    bus.ALUresult    = {widx_q, 2'b00};
                end
                default: ;
            endcase
        end
    end

    // Registered load result, pulses and RMW buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            buffer_q     <= '0;
            widx_q       <= '0;
        end else begin
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            if ((state_q == IDLE) && bus.req_valid) begin
                if (is_fault) begin
                    fault_q <= 1'b1;
                end else if (!bus.req_write) begin
                    load_data_q  <= load_ext;
                    load_valid_q <= 1'b1;
                end else if (is_rmw) begin
                    buffer_q <= merged;
                    widx_q   <= bus.addr[31:2];
                end
            end
        end
    end

    assign bus.load_data  = load_data_q;
    assign bus.load_valid = load_valid_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory model.
module tb_load_store_unit;
    localparam int unsigned WORDS = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge
    assign bus.MemReadData = mem[bus.ALUresult[6:2]];
    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.ALUresult[6:2]] <= bus.MemWriteData;
    end

    typedef struct {
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] d;
        bit [31:0] exp;
        bit        exp_fault;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_fault(input bit [2:0] f3, input bit [31:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
        if (f3 == 2 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input bit [31:0] a, input bit [2:0] f3);
        int unsigned off;
        int b;
        int h;
        off = a % 4;
        b = int'((w >> (8 * off)) & 32'hFF);
        h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input bit [31:0] a,
                                              input bit [2:0] f3, input bit [31:0] d);
        int unsigned off;
        int unsigned sh;
        logic [31:0] m;
        off = a % 4;
        if (f3[0]) begin
            sh = 16 * (off / 2);
            m  = 32'hFFFF << sh;
        end else begin
            sh = 8 * off;
            m  = 32'hFF << sh;
        end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // One request through the unit, checked against the model; returns the
    // load result or written word, plus the fault pulse seen.
    task automatic do_access(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                             input bit [31:0] d, output bit [31:0] obs, output bit obs_fault);
        bit          ef;
        bit          rmw;
        int unsigned idx;
        logic [31:0] ew;
        ef  = ref_fault(f3, a);
        rmw = wr && !ef && (f3[1:0] != 2'd2);
        idx = (a / 4) % WORDS;
        obs = 32'h0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = d;
        @(negedge clk);
        check("ALUresult", bus.ALUresult, {a[31:2], 2'b00});
        check("MemRead", 32'(bus.MemRead), 32'(!ef && (!wr || rmw)));
        check("MemWrite", 32'(bus.MemWrite), 32'(!ef && wr && !rmw));
        check("stall", 32'(bus.stall), 32'(rmw));
        if (!ef && wr && !rmw) begin
            check("MemWriteData_sw", bus.MemWriteData, d);
            obs = bus.MemWriteData;
            ref_mem[idx] = d;
        end
        @(posedge clk);
        #1;
        obs_fault = bus.fault;
        check("fault", 32'(bus.fault), 32'(ef));
        check("load_valid", 32'(bus.load_valid), 32'(!wr && !ef));
        if (!wr && !ef) begin
            check("load_data", bus.load_data, ref_load(ref_mem[idx], a, f3));
            obs = bus.load_data;
        end
        if (rmw) begin
            ew = ref_merge(ref_mem[idx], a, f3, d);
            @(negedge clk);
            check("rmw_MemWrite", 32'(bus.MemWrite), 32'h1);
            check("rmw_MemRead", 32'(bus.MemRead), 32'h0);
            check("rmw_stall", 32'(bus.stall), 32'h0);
            check("rmw_ALUresult", bus.ALUresult, {a[31:2], 2'b00});
            check("rmw_MemWriteData", bus.MemWriteData, ew);
            obs = bus.MemWriteData;
            ref_mem[idx] = ew;
            @(posedge clk);
            #1;
            check("rmw_load_valid", 32'(bus.load_valid), 32'h0);
            check("rmw_fault", 32'(bus.fault), 32'h0);
        end
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("idle_MemRead", 32'(bus.MemRead), 32'h0);
        check("idle_MemWrite", 32'(bus.MemWrite), 32'h0);
        check("idle_ALUresult", bus.ALUresult, 32'h0);
        @(posedge clk);
        #1;
        check("idle_load_valid", 32'(bus.load_valid), 32'h0);
        check("idle_fault", 32'(bus.fault), 32'h0);
    endtask

    initial begin
        vec_t        vecs[$];
        bit [31:0]   obs;
        bit          obs_f;
        bit          wr;
        bit [2:0]    f3;
        bit [31:0]   a;

        checks = 0;
        errors = 0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     <= 32'h0;
            ref_mem[i]  = 32'h0;
        end
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.funct3     = 3'd0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        #2;
        check("rst_load_data", bus.load_data, 32'h0);
        check("rst_load_valid", 32'(bus.load_valid), 32'h0);
        check("rst_fault", 32'(bus.fault), 32'h0);
        check("rst_MemRead", 32'(bus.MemRead), 32'h0);
        check("rst_MemWrite", 32'(bus.MemWrite), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_MemWriteData", bus.MemWriteData, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed expectations
        vecs.push_back('{1, 3'd2, 32'h08, 32'h80FF1234, 32'h80FF1234, 0});
        vecs.push_back('{0, 3'd0, 32'h0B, 32'h0,        32'hFFFFFF80, 0});
        vecs.push_back('{0, 3'd4, 32'h0B, 32'h0,        32'h00000080, 0});
        vecs.push_back('{0, 3'd1, 32'h0A, 32'h0,        32'hFFFF80FF, 0});
        vecs.push_back('{0, 3'd5, 32'h0A, 32'h0,        32'h000080FF, 0});
        vecs.push_back('{1, 3'd0, 32'h09, 32'h000000AB, 32'h80FFAB34, 0});
        vecs.push_back('{0, 3'd2, 32'h08, 32'h0,        32'h80FFAB34, 0});
        vecs.push_back('{1, 3'd2, 32'h00, 32'h00000015, 32'h00000015, 0});
        vecs.push_back('{1, 3'd1, 32'h02, 32'h0000BEEF, 32'hBEEF0015, 0});
        vecs.push_back('{0, 3'd2, 32'h00, 32'h0,        32'hBEEF0015, 0});
        vecs.push_back('{0, 3'd2, 32'h06, 32'h0,        32'h0,        1});
        vecs.push_back('{1, 3'd1, 32'h03, 32'h0000BEEF, 32'h0,        1});
        vecs.push_back('{0, 3'd3, 32'h00, 32'h0,        32'h0,        1});
        vecs.push_back('{0, 3'd2, 32'h80, 32'h0,        32'h0,        1});
        foreach (vecs[i]) begin
            do_access(vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, obs, obs_f);
            check($sformatf("vec%0d_fault", i), 32'(obs_f), 32'(vecs[i].exp_fault));
            if (!vecs[i].exp_fault) check($sformatf("vec%0d_value", i), obs, vecs[i].exp);
        end
        idle_cycle();

        // Reset asserted in the RMW write cycle: no write reaches memory
        mem[5]     <= 32'h11223344;
        ref_mem[5]  = 32'h11223344;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.funct3     = 3'd0;
        bus.addr       = 32'h14;
        bus.store_data = 32'h55;
        @(negedge clk);
        check("rstrmw_stall", 32'(bus.stall), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstrmw_in_wr", 32'(bus.MemWrite), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("rstrmw_MemWrite", 32'(bus.MemWrite), 32'h0);
        check("rstrmw_MemRead", 32'(bus.MemRead), 32'h0);
        check("rstrmw_stall0", 32'(bus.stall), 32'h0);
        check("rstrmw_MemWriteData", bus.MemWriteData, 32'h0);
        check("rstrmw_load_data", bus.load_data, 32'h0);
        check("rstrmw_load_valid", 32'(bus.load_valid), 32'h0);
        check("rstrmw_fault", 32'(bus.fault), 32'h0);
        @(posedge clk);
        #1;
        check("rstrmw_mem", mem[5], 32'h11223344);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 3'd2, 32'h14, 32'h0, obs, obs_f);
        check("rstrmw_readback", obs, 32'h11223344);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle();
            end else begin
                wr = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                if (wr && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
                if ($urandom_range(0, 19) == 0) a = $urandom;
                else a = 32'($urandom_range(0, 4 * WORDS - 1));
                if (f3[1:0] == 2'd2 && $urandom_range(0, 3) != 0) a = a & ~32'h3;
                if (f3[1:0] == 2'd1 && $urandom_range(0, 3) != 0) a = a & ~32'h1;
                do_access(wr, f3, a, $urandom, obs, obs_f);
            end
        end
        idle_cycle();

        for (int i = 0; i < WORDS; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
